// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the MEM-side byte sequencer: size codes, FSM states
// and the latched request record.
package mem_ctrl_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    MEMCTRL_IDLE   = 2'd0,
    MEMCTRL_ACCESS = 2'd1,
    MEMCTRL_TAIL   = 2'd2,
    MEMCTRL_DONE   = 2'd3
  } memctrl_state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
  } mem_req_t;

  // Size code 11 is treated as a word.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: size_nbytes = 3'd1;
      MEM_SIZE_H: size_nbytes = 3'd2;
      default:    size_nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load value.
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] ext
);

  always_comb begin
    case (size)
      MEM_SIZE_B: ext = {{24{sext & raw[7]}}, raw[7:0]};
      MEM_SIZE_H: ext = {{16{sext & raw[15]}}, raw[15:0]};
      default:    ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Sequences one byte/half/word load or store into single-byte RAM accesses,
// little-endian, and hands MEM a request/done handshake.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [1:0]                size_i,
  input  logic                      sext_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [31:0]               rdata_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a_o,
  output logic                      ram_wr_o,
  output logic [7:0]                ram_d_o,
  input  logic [7:0]                ram_d_i
);

  memctrl_state_e            state_q;
  mem_req_t                  req_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [2:0]                idx_q;
  logic [2:0]                nbytes_q;
  logic [31:0]               asm_q;
  logic [31:0]               asm_next;
  logic [31:0]               ext;
  logic                      cap_en;
  logic [1:0]                cap_sel;
  logic                      last_byte;

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:RAM_ADDR_WIDTH];

  assign busy_o    = (state_q != MEMCTRL_IDLE);
  assign last_byte = (idx_q == nbytes_q - 3'd1);

  // Read data lags its address by one edge, so ACCESS idx captures byte idx-1
  // and TAIL picks up the final byte.
  always_comb begin
    cap_en  = 1'b0;
    cap_sel = 2'd0;
    if (state_q == MEMCTRL_ACCESS && !req_q.we && idx_q != 3'd0) begin
      cap_en  = 1'b1;
      cap_sel = idx_q[1:0] - 2'd1;
    end else if (state_q == MEMCTRL_TAIL) begin
      cap_en  = 1'b1;
      cap_sel = nbytes_q[1:0] - 2'd1;
    end
    asm_next = asm_q;
    if (cap_en) asm_next[{cap_sel, 3'b000} +: 8] = ram_d_i;
  end

  mem_load_ext u_ext (
    .raw  (asm_next),
    .size (req_q.size),
    .sext (req_q.sext),
    .ext  (ext)
  );

  always_comb begin
    ram_a_o  = '0;
    ram_wr_o = 1'b0;
    ram_d_o  = '0;
    if (state_q == MEMCTRL_ACCESS) begin
      ram_a_o = addr_q + RAM_ADDR_WIDTH'(idx_q);
      if (req_q.we) begin
        ram_wr_o = 1'b1;
        ram_d_o  = req_q.wdata[{idx_q[1:0], 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MEMCTRL_IDLE;
      req_q    <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      nbytes_q <= '0;
      asm_q    <= '0;
      done_o   <= 1'b0;
      rdata_o  <= '0;
    end else begin
      case (state_q)
        MEMCTRL_IDLE: begin
          done_o <= 1'b0;
          if (req_i) begin
            req_q    <= '{we: we_i, size: size_i, sext: sext_i, wdata: wdata_i};
            addr_q   <= addr_i[RAM_ADDR_WIDTH-1:0];
            nbytes_q <= size_nbytes(size_i);
            idx_q    <= '0;
            asm_q    <= '0;
            state_q  <= MEMCTRL_ACCESS;
          end
        end
        MEMCTRL_ACCESS: begin
          asm_q <= asm_next;
          idx_q <= idx_q + 3'd1;
          if (last_byte) begin
            state_q <= req_q.we ? MEMCTRL_DONE : MEMCTRL_TAIL;
            done_o  <= req_q.we;
          end
        end
        MEMCTRL_TAIL: begin
          asm_q   <= asm_next;
          rdata_o <= ext;
          done_o  <= 1'b1;
          state_q <= MEMCTRL_DONE;
        end
        default: begin
          done_o  <= 1'b0;
          state_q <= MEMCTRL_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl against a behavioural byte-wide sync RAM.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        sext_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        busy_o, done_o;
  logic [31:0] rdata_o;
  logic [16:0] ram_a_o;
  logic        ram_wr_o;
  logic [7:0]  ram_d_o;
  logic [7:0]  ram_d_i = '0;

  always #5 clk = ~clk;

  mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sext_i(sext_i), .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o),
    .done_o(done_o), .rdata_o(rdata_o), .ram_a_o(ram_a_o),
    .ram_wr_o(ram_wr_o), .ram_d_o(ram_d_o), .ram_d_i(ram_d_i)
  );

  logic [7:0] mem [0:131071];
  logic       filled = 1'b0;

  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 131072; i++) mem[i] <= 8'h5A;
      filled <= 1'b1;
    end else begin
      if (ram_wr_o) mem[ram_a_o] <= ram_d_o;
      ram_d_i <= mem[ram_a_o];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd = '0;
  logic        done_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done_o) begin
      checks++;
      if (done_prev) begin
        errors++;
        $display("FAIL done_width: done_o high two cycles in a row");
      end
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_done: got done_o with nothing outstanding at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk({e.name, "_rdata"}, rdata_o, e.data);
        chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    done_prev = done_o;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) begin
      errors++;
      $display("FAIL idle_timeout: busy_o still %b after %0d cycles", busy_o, n);
    end
  endtask

  task automatic issue(input string nm, input logic we, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input int lat);
    exp_t e;
    wait_idle();
    req_i = 1'b1; we_i = we; size_i = sz; sext_i = sx; addr_i = a; wdata_i = wd;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    chk({nm, "_busy"}, {31'd0, busy_o}, 32'd1);
    if (!we) last_rd = exp_rd;
    e.data = last_rd; e.lat = lat; e.acc = cyc; e.name = nm;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy_o) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0 || busy_o) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, busy_o %b", q.size(), busy_o);
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_busy"},  {31'd0, busy_o}, 32'd0);
    chk({nm, "_done"},  {31'd0, done_o}, 32'd0);
    chk({nm, "_rdata"}, rdata_o, 32'd0);
    chk({nm, "_ram_a"}, {15'd0, ram_a_o}, 32'd0);
    chk({nm, "_ram_wr"}, {31'd0, ram_wr_o}, 32'd0);
    chk({nm, "_ram_d"}, {24'd0, ram_d_o}, 32'd0);
  endtask

  initial begin
    int acc;
    exp_t e;
    #1;
    chk_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // word store then read-back in several widths
    issue("st_w100", 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0FF0_0FF0, '0, 4);
    drain();
    chk("mem100", {24'd0, mem[17'h100]}, 32'hF0);
    chk("mem101", {24'd0, mem[17'h101]}, 32'h0F);
    chk("mem102", {24'd0, mem[17'h102]}, 32'hF0);
    chk("mem103", {24'd0, mem[17'h103]}, 32'h0F);
    issue("ld_w100", 1'b0, 2'b10, 1'b0, 32'h0000_0100, '0, 32'h0FF0_0FF0, 5);
    issue("ld_bs100", 1'b0, 2'b00, 1'b1, 32'h0000_0100, '0, 32'hFFFF_FFF0, 2);
    issue("ld_bz100", 1'b0, 2'b00, 1'b0, 32'h0000_0100, '0, 32'h0000_00F0, 2);
    issue("ld_hs101", 1'b0, 2'b01, 1'b1, 32'h0000_0101, '0, 32'hFFFF_F00F, 3);
    issue("ld_sz3", 1'b0, 2'b11, 1'b1, 32'hFFFE_0100, '0, 32'h0FF0_0FF0, 5);
    drain();

    // half store across the address wrap
    issue("st_hwrap", 1'b1, 2'b01, 1'b0, 32'h0001_FFFF, 32'h1234_BEEF, '0, 2);
    drain();
    chk("mem1ffff", {24'd0, mem[17'h1FFFF]}, 32'hEF);
    chk("mem00000", {24'd0, mem[17'h00000]}, 32'hBE);
    issue("ld_hwrap", 1'b0, 2'b01, 1'b0, 32'h0001_FFFF, '0, 32'h0000_BEEF, 3);
    drain();

    // req_i held high across two word stores
    wait_idle();
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; sext_i = 1'b0;
    addr_i = 32'h0000_0300; wdata_i = 32'hCAFE_BABE;
    @(posedge clk);
    #1;
    acc = cyc;
    e.data = last_rd; e.lat = 4; e.acc = acc;     e.name = "b2b_first";  q.push_back(e);
    e.data = last_rd; e.lat = 4; e.acc = acc + 6; e.name = "b2b_second"; q.push_back(e);
    repeat (6) @(posedge clk);
    #1;
    req_i = 1'b0;
    chk("b2b_second_busy", {31'd0, busy_o}, 32'd1);
    drain();
    chk("mem300", {24'd0, mem[17'h300]}, 32'hBE);
    chk("mem303", {24'd0, mem[17'h303]}, 32'hCA);

    // reset in the middle of a word store
    issue("st_rst", 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h1122_3344, '0, 4);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    q.delete();
    last_rd = '0;
    @(negedge clk);
    rst = 1'b1;
    chk("mem200", {24'd0, mem[17'h200]}, 32'h44);
    chk("mem201", {24'd0, mem[17'h201]}, 32'h33);
    chk("mem202", {24'd0, mem[17'h202]}, 32'h5A);
    chk("mem203", {24'd0, mem[17'h203]}, 32'h5A);
    issue("ld_after_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0200, '0, 32'h5A5A_3344, 5);
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
